instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit_pkg.sv | 22 ++
 rtl/instr_fetch_unit_fetch_fifo.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage.
//   XLEN / INSTR_BYTES : datapath width and instruction size in bytes
//   RESET_PC_DEFAULT   : default fetch address after reset
//   fetch_state_e      : fetch FSM states (BOOT, RUN, FLUSH)
//   align_pc()         : forces a byte address onto a word boundary
package instr_fetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs.
//   clk, reset_n : clock, asynchronous active-low reset
//   push/push_data : write one entry (accepted when not full, or when full and popping)
//   pop            : remove the head entry (ignored when empty)
//   flush          : empty the FIFO; overrides push and pop in the same cycle
//   count          : number of valid entries (0..DEPTH)
//   head_valid/head_data : head entry; head_data reads 0 while empty
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop     = pop && (count != '0) && !flush;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push    = push && !flush && ((count < CW'(DEPTH)) || do_pop);
    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observable through head_data,
    // which is gated by head_valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches over a
// request/grant interface, buffers returned words with their PC and hands
// them to the decoder. Redirects reload the PC, flush buffered words and
// drop responses that were already in flight.
//   clk, reset_n           : clock, asynchronous active-low reset
//   imem_req/addr/gnt      : fetch request, word-aligned address, grant
//   imem_rvalid/rdata      : in-order response word
//   redirect_valid/target  : one-cycle branch/jump redirect and new PC
//   instr_valid/ready      : decoder handshake
//   instr/instr_pc         : head word and its PC
//   fsm_state              : current fetch FSM state (observation only)
//
// Handshakes: a request transfers in a cycle where imem_req & imem_gnt; a
// response transfers whenever imem_rvalid is high (no back-pressure); an
// instruction transfers in a cycle where instr_valid & instr_ready. A valid
// source holds its payload until the transfer, except that a redirect
// withdraws both imem_req and the buffered instructions.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output fetch_state_e    fsm_state
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   discard_next;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_use;
    logic            granted;
    logic            accept_word;
    logic            fifo_pop;
    logic [2*XLEN-1:0] head_data;

    // Credit: every granted request already owns a FIFO slot, so requests in
    // flight plus buffered words never exceed DEPTH.
    assign in_use      = {1'b0, outstanding} + {1'b0, fifo_count};
    assign granted     = imem_req && imem_gnt;
    assign accept_word = imem_rvalid && (discard == '0) && !redirect_valid;
    assign fifo_pop    = instr_valid && instr_ready && !redirect_valid;

    assign imem_addr   = fetch_pc;
    assign fsm_state   = state;
    assign instr_pc    = head_data[2*XLEN-1:XLEN];
    assign instr       = head_data[XLEN-1:0];

    always_comb begin
        state_next   = state;
        discard_next = discard;
        imem_req     = 1'b0;

        // Discard is recomputed on every redirect from what is still in
        // flight; a response landing in the redirect cycle is dropped too.
        if (redirect_valid) begin
            discard_next = outstanding - CW'(imem_rvalid);
        end else if (imem_rvalid && (discard != '0)) begin
            discard_next = discard - 1'b1;
        end

        case (state)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN, ST_FLUSH: begin
                imem_req   = !redirect_valid && (in_use < (CW + 1)'(DEPTH));
                state_next = (discard_next != '0) ? ST_FLUSH : ST_RUN;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_BOOT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state   <= state_next;
            discard <= discard_next;

            case ({granted, imem_rvalid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (redirect_valid) begin
                fetch_pc <= align_pc(redirect_target);
                resp_pc  <= align_pc(redirect_target);
            end else begin
                if (granted)     fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
                if (accept_word) resp_pc  <= resp_pc + XLEN'(INSTR_BYTES);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (accept_word),
        .push_data  ({resp_pc, imem_rdata}),
        .pop        (fifo_pop),
        .flush      (redirect_valid),
        .count      (fifo_count),
        .head_valid (instr_valid),
        .head_data  (head_data)
    );

endmodule
